spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter_if.sv | 39 +++
 rtl/spi_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/spi_arbiter_if.sv
// Bundle of requester-side and SPI-master-side signals around spi_arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface spi_arbiter_if #(
    parameter int MAX_BYTES_PER_CS = 2
);
    localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);

    logic [1:0]      req;
    logic [2*CW-1:0] req_count;
    logic [15:0]     req_byte;
    logic [1:0]      req_byte_valid;
    logic [1:0]      req_byte_ready;
    logic [1:0]      gnt;
    logic [1:0]      rsp_valid;
    logic [7:0]      rsp_byte;
    logic [1:0]      done;
    logic [1:0]      err;
    logic [CW-1:0]   m_TX_Count;
    logic [7:0]      m_TX_Byte;
    logic            m_TX_valid;
    logic            m_TX_start;
    logic            m_RX_valid;
    logic [7:0]      m_RX_Byte;
    logic            m_CS_n;

    modport master (
        input  req, req_count, req_byte, req_byte_valid,
               m_TX_start, m_RX_valid, m_RX_Byte, m_CS_n,
        output req_byte_ready, gnt, rsp_valid, rsp_byte, done, err,
               m_TX_Count, m_TX_Byte, m_TX_valid
    );

    modport slave (
        output req, req_count, req_byte, req_byte_valid,
               m_TX_start, m_RX_valid, m_RX_Byte, m_CS_n,
        input  req_byte_ready, gnt, rsp_valid, rsp_byte, done, err,
               m_TX_Count, m_TX_Byte, m_TX_valid
    );
endinterface

// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter in front of a chip-select SPI master.
// Grant is held for a whole CS transaction; RX bytes are routed to the owner.
module spi_arbiter #(
    parameter int MAX_BYTES_PER_CS = 2,
    parameter int TIMEOUT_CLKS     = 255
) (
    input  logic         system_clk,
    input  logic         reset,
    spi_arbiter_if.master bus
);
    localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
    localparam int WW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [31:0] MAX_U = MAX_BYTES_PER_CS;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RX} state_t;

    state_t        state;
    logic [1:0]    gnt_q;
    logic [1:0]    done_q;
    logic [1:0]    err_q;
    logic          last_gnt;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] tx_left;
    logic [CW-1:0] rx_left;
    logic [WW-1:0] wd;

    logic          win;
    logic [CW-1:0] win_cnt;
    logic          win_ok;
    logic          accept;
    logic          rx_hit;

    // On a tie the requester that was not served last wins.
    always_comb begin
        win = 1'b0;
        if (bus.req == 2'b11) win = ~last_gnt;
        else                  win = bus.req[1];
        win_cnt = win ? bus.req_count[CW +: CW] : bus.req_count[0 +: CW];
        win_ok  = (win_cnt != '0) && (32'(win_cnt) <= MAX_U);
    end

    assign bus.req_byte_ready = (state == SEND) ? (gnt_q & {2{bus.m_TX_start}}) : '0;
    assign accept             = |(bus.req_byte_ready & bus.req_byte_valid);
    assign bus.m_TX_valid     = accept;
    assign bus.m_TX_Byte      = gnt_q[1] ? bus.req_byte[15:8] : bus.req_byte[7:0];
    assign bus.m_TX_Count     = (|gnt_q) ? cnt_q : '0;

    assign rx_hit        = ((state == SEND) || (state == WAIT_RX)) &&
                           bus.m_RX_valid && (rx_left != '0);
    assign bus.rsp_valid = rx_hit ? gnt_q : '0;
    assign bus.rsp_byte  = rx_hit ? bus.m_RX_Byte : '0;
    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    always_ff @(posedge system_clk) begin
        if (!reset) begin
            state    <= IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            last_gnt <= 1'b1;
            cnt_q    <= '0;
            tx_left  <= '0;
            rx_left  <= '0;
            wd       <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            if (rx_hit) rx_left <= rx_left - CW'(1);
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        if (win_ok) begin
                            gnt_q   <= win ? 2'b10 : 2'b01;
                            cnt_q   <= win_cnt;
                            tx_left <= win_cnt;
                            rx_left <= win_cnt;
                            state   <= SEND;
                        end else begin
                            err_q <= win ? 2'b10 : 2'b01;
                        end
                    end
                end
                SEND: begin
                    if (accept) begin
                        tx_left <= tx_left - CW'(1);
                        if (tx_left == CW'(1)) begin
                            state <= WAIT_RX;
                            wd    <= '0;
                        end
                    end
                end
                WAIT_RX: begin
                    if ((rx_left == '0) && bus.m_CS_n) begin
                        done_q   <= gnt_q;
                        gnt_q    <= '0;
                        last_gnt <= gnt_q[1];
                        state    <= IDLE;
                    end else if (wd == WW'(TIMEOUT_CLKS - 1)) begin
                        err_q    <= gnt_q;
                        gnt_q    <= '0;
                        last_gnt <= gnt_q[1];
                        state    <= IDLE;
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= '0;
                end
            endcase
        end
    end
endmodule
